// File: rtl/inst_prefetch_pkg.sv
// Shared widths, depth and FSM encoding for the instruction prefetch buffer.
package inst_prefetch_pkg;

    localparam int INST_ADDR_BUS = 32;
    localparam int INST_BUS      = 32;
    localparam int PF_DEPTH      = 4;

    localparam logic [INST_BUS-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        PF_IDLE = 2'd0,
        PF_REQ  = 2'd1,
        PF_WAIT = 2'd2
    } pf_state_e;

endpackage

// File: rtl/pf_fifo.sv
// Small synchronous FIFO of {addr, inst} entries; head is visible without a pop.
module pf_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every use of the head entry.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/inst_prefetch.sv
// Sequential instruction prefetcher between the core ROM port and a req/gnt/rvalid memory.
module inst_prefetch
    import inst_prefetch_pkg::*;
#(
    parameter int DEPTH  = PF_DEPTH,
    parameter int ADDR_W = INST_ADDR_BUS,
    parameter int DATA_W = INST_BUS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_ce_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic              core_take_i,
    output logic [DATA_W-1:0] core_inst_o,
    output logic              core_valid_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    pf_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  fetch_addr_q, fetch_addr_d;
    logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
    logic               drop_q, drop_d;
    logic               synced_q, synced_d;

    logic [ADDR_W+DATA_W-1:0] head_data;
    logic [CNT_W-1:0]         count;
    logic [ADDR_W-1:0]        head_addr;
    logic [ADDR_W-1:0]        expected_addr;
    logic                     not_empty, hit, pop, push, flush, redirect, room;

    assign head_addr     = head_data[ADDR_W+DATA_W-1:DATA_W];
    assign not_empty     = (count != '0);
    assign expected_addr = not_empty ? head_addr : fetch_addr_q;
    assign redirect      = core_ce_i & (~synced_q | (core_addr_i != expected_addr));
    assign hit           = core_ce_i & not_empty & (head_addr == core_addr_i);
    assign pop           = hit & core_take_i;
    assign flush         = redirect | ~core_ce_i;
    // A response is kept only if nothing invalidated it while in flight or this cycle.
    assign push          = (state_q == PF_WAIT) & mem_rvalid_i & core_ce_i & ~drop_q & ~redirect;
    assign room          = flush | pop | (count != CNT_W'(DEPTH));

    assign core_valid_o = hit;
    assign core_inst_o  = hit ? head_data[DATA_W-1:0] : ZERO_WORD;
    assign mem_req_o    = (state_q == PF_REQ);
    assign mem_addr_o   = mem_req_o ? req_addr_q : '0;

    pf_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .pop       (pop),
        .push_data ({fetch_addr_q, mem_rdata_i}),
        .head_data (head_data),
        .count     (count)
    );

    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        drop_d       = drop_q;
        synced_d     = core_ce_i ? (synced_q | redirect) : 1'b0;
        fetch_addr_d = fetch_addr_q;
        if (redirect)  fetch_addr_d = core_addr_i;
        else if (push) fetch_addr_d = fetch_addr_q + ADDR_W'(4);

        unique case (state_q)
            PF_IDLE: begin
                if (core_ce_i && synced_d && room) begin
                    state_d    = PF_REQ;
                    req_addr_d = fetch_addr_d;
                end
            end
            PF_REQ: begin
                if (mem_gnt_i) state_d = PF_WAIT;
                if (flush)     drop_d  = 1'b1;
            end
            PF_WAIT: begin
                if (mem_rvalid_i) begin
                    state_d = PF_IDLE;
                    drop_d  = 1'b0;
                end else if (flush) begin
                    drop_d  = 1'b1;
                end
            end
            default: state_d = PF_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= PF_IDLE;
            fetch_addr_q <= '0;
            req_addr_q   <= '0;
            drop_q       <= 1'b0;
            synced_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            req_addr_q   <= req_addr_d;
            drop_q       <= drop_d;
            synced_q     <= synced_d;
        end
    end

endmodule
